// File: rtl/jbcd_subtractor_serial.sv
// Purpose : digit-serial packed-BCD subtractor, Y = A - B - borrowin, LSD first, with borrow-out.
// Latency : DIGITS cycles from the start edge to the done pulse; one operation per DIGITS+2 cycles.
// Backpres: none; start is only accepted in IDLE, and a start seen while busy or done is dropped.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             request, sampled only in IDLE; A/B/borrowin are captured on that edge
//   A, B              minuend / subtrahend, packed BCD, digit 0 in [3:0]
//   borrowin          borrow into digit 0
//   Y, borrowout      difference (ten's complement when borrowout=1) and top-digit borrow
//   busy              high while digits are being processed
//   done              one-cycle pulse; Y/borrowout/invalid are updated as done rises
//   invalid           set with done if any operand digit was above 9
module jbcd_subtractor_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  borrowin,
    output logic [4*DIGITS-1:0]   Y,
    output logic                  borrowout,
    output logic                  busy,
    output logic                  done,
    output logic                  invalid
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [4*DIGITS-1:0] r_a;
    logic [4*DIGITS-1:0] r_b;
    logic [4*DIGITS-1:0] r_res;
    logic [CW-1:0]       r_cnt;
    logic                r_br;
    logic                r_inv_acc;
    logic [4*DIGITS-1:0] r_y;
    logic                r_bo;
    logic                r_inv;

    logic [3:0]          w_a_dig;
    logic [3:0]          w_b_dig;
    logic [4:0]          w_diff;
    logic [4:0]          w_diff_adj;
    logic [3:0]          w_digit;
    logic                w_br_nxt;
    logic                w_inv_nxt;
    logic                w_last;
    logic [4*DIGITS-1:0] w_res_full;

    // ---------------------------------------------------------------
    // Per-digit datapath
    // ---------------------------------------------------------------
    assign w_a_dig = r_a[4*r_cnt +: 4];
    assign w_b_dig = r_b[4*r_cnt +: 4];

    // 5-bit subtraction: bit 4 is the sign, i.e. this digit borrows.
    assign w_diff     = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {4'b0, r_br};
    assign w_diff_adj = w_diff + 5'd10;
    assign w_digit    = w_diff[4] ? w_diff_adj[3:0] : w_diff[3:0];
    assign w_br_nxt   = w_diff[4];
    assign w_inv_nxt  = r_inv_acc | (w_a_dig > 4'd9) | (w_b_dig > 4'd9);
    assign w_last     = (r_cnt == LAST);

    // Result with the current digit merged in, so the final digit can be
    // published to Y on the same edge it is computed.
    always_comb begin
        w_res_full                = r_res;
        w_res_full[4*r_cnt +: 4]  = w_digit;
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Working and output registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_cnt     <= '0;
            r_br      <= 1'b0;
            r_inv_acc <= 1'b0;
            r_y       <= '0;
            r_bo      <= 1'b0;
            r_inv     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a       <= A;
                        r_b       <= B;
                        r_br      <= borrowin;
                        r_res     <= '0;
                        r_cnt     <= '0;
                        r_inv_acc <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_res     <= w_res_full;
                    r_br      <= w_br_nxt;
                    r_inv_acc <= w_inv_nxt;
                    r_cnt     <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cnt <= '0;
                        r_y   <= w_res_full;
                        r_bo  <= w_br_nxt;
                        r_inv <= w_inv_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Y         = r_y;
    assign borrowout = r_bo;
    assign invalid   = r_inv;

endmodule

// File: tb/tb_jbcd_subtractor_serial.sv
module tb_jbcd_subtractor_serial;

    localparam int DIGITS = 4;

    logic                clk;
    logic                reset;
    logic                start;
    logic [4*DIGITS-1:0] A;
    logic [4*DIGITS-1:0] B;
    logic                borrowin;
    logic [4*DIGITS-1:0] Y;
    logic                borrowout;
    logic                busy;
    logic                done;
    logic                invalid;

    int errors = 0;
    int checks = 0;

    jbcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .borrowin  (borrowin),
        .Y         (Y),
        .borrowout (borrowout),
        .busy      (busy),
        .done      (done),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] exp_y;
        logic        exp_bo;
        logic        exp_inv;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge with the DUT idle. Runs one operation and
    // returns at the negedge after the done cycle (DUT idle again).
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        int busy_cnt;
        int both;
        lat      = -1;
        busy_cnt = 0;
        both     = 0;
        A        = v.a;
        B        = v.b;
        borrowin = v.bi;
        start    = 1'b1;
        @(posedge clk);                 // E0
        @(negedge clk);
        start    = 1'b0;
        A        = 16'hFFFF;            // operands are don't-care after E0
        B        = 16'h7777;
        borrowin = 1'b1;
        if (busy) busy_cnt++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy && done) both++;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: done never seen, expected within 20 cycles", tag);
            return;
        end
        chk({tag, " latency"},    lat,        4);
        chk({tag, " busy_cnt"},   busy_cnt,   4);
        chk({tag, " busy&done"},  both,       0);
        chk({tag, " Y"},          {16'h0, Y}, {16'h0, v.exp_y});
        chk({tag, " borrowout"},  {31'h0, borrowout}, {31'h0, v.exp_bo});
        chk({tag, " invalid"},    {31'h0, invalid},   {31'h0, v.exp_inv});
        @(negedge clk);
        chk({tag, " done_pulse"}, {31'h0, done}, 32'h0);
    endtask

    vec_t vecs[$];

    initial begin
        int done_cnt;
        vec_t v;

        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{16'h5432, 16'h1234, 1'b0, 16'h4198, 1'b0, 1'b0});
        vecs.push_back('{16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0});
        vecs.push_back('{16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0});
        vecs.push_back('{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0});
        vecs.push_back('{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0});
        vecs.push_back('{16'h000F, 16'h0000, 1'b0, 16'h000F, 1'b0, 1'b1});
        vecs.push_back('{16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0});
        vecs.push_back('{16'h0000, 16'h00A0, 1'b0, 16'h9900, 1'b1, 1'b1});
        vecs.push_back('{16'h8642, 16'h7531, 1'b1, 16'h1110, 1'b0, 1'b0});

        reset    = 1'b1;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        borrowin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst Y",         {16'h0, Y},         32'h0);
        chk("rst borrowout", {31'h0, borrowout}, 32'h0);
        chk("rst busy",      {31'h0, busy},      32'h0);
        chk("rst done",      {31'h0, done},      32'h0);
        chk("rst invalid",   {31'h0, invalid},   32'h0);

        // Reset coinciding with start: must stay idle.
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        chk("rst+start busy", {31'h0, busy}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // start pulsed again mid-RUN with different operands: ignored.
        A = 16'h5432; B = 16'h1234; borrowin = 1'b0; start = 1'b1;
        @(posedge clk);                 // E0
        @(negedge clk);
        start = 1'b0; A = 16'h0000; B = 16'h0001;
        @(posedge clk);                 // E1
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);                 // E2, in RUN
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) done_cnt++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("midstart done_cnt",  done_cnt,          1);
        chk("midstart Y",         {16'h0, Y},         32'h4198);
        chk("midstart borrowout", {31'h0, borrowout}, 32'h0);

        // Reset sampled at the 2nd RUN edge aborts the operation.
        A = 16'h0000; B = 16'h0001; borrowin = 1'b0; start = 1'b1;
        @(posedge clk);                 // E0
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);                 // E1
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);                 // E2
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", {31'h0, busy}, 32'h0);
        chk("abort Y",    {16'h0, Y},    32'h0);
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (done || busy) done_cnt++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort no_done", done_cnt, 0);

        v = '{16'h2001, 16'h0999, 1'b0, 16'h1002, 1'b0, 1'b0};
        run_op(v, "post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
